// File: rtl/decoder_arb_pkg.sv
// Shared types and sizes for the round-robin arbiter feeding the 2-to-4 decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package decoder_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request starting at ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; any=0 means no request, and idx is then don't-care (0 offset).
//
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    highest-priority index
//   idx  out IDX_W    picked index
//   any  out 1        at least one request present
module rr_pick
    import decoder_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     off;

    // Rotate right by ptr so that position 0 of rot is requester ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    // Find-first from the bottom: scan downward so the lowest set bit wins.
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Rotate back; the IDX_W-bit add wraps modulo NUM_REQ.
    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 enable decoder: registered owner address + enable.
// Latency: request seen at an edge -> enable=1 after that edge; one dead cycle between owners.
// Backpressure: none; grants are bounded to MAX_HOLD cycles when others wait.
//
// Ports:
//   clk       in   1  rising-edge clock
//   rst_n     in   1  asynchronous active-low reset
//   req       in   4  level-sensitive requests
//   address0  out  1  owner index bit 0 (registered)
//   address1  out  1  owner index bit 1 (registered)
//   enable    out  1  grant valid (registered)
//   busy      out  1  high in GRANT or GAP (registered)
module rr_decoder_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic               address0,
    output logic               address1,
    output logic               enable,
    output logic               busy
);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   cnt;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] owner_mask;
    logic               owner_req;
    logic               others_req;
    logic               expired;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_mask = NUM_REQ'(1) << owner;
    assign owner_req  = |(req & owner_mask);
    assign others_req = |(req & ~owner_mask);
    assign expired    = (cnt == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            cnt    <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                // IDLE and GAP arbitrate identically; in GAP ptr already points past the
                // previous owner, which may still win if it is the only requester.
                IDLE, GAP: begin
                    if (pick_any) begin
                        state  <= GRANT;
                        owner  <= pick_idx;
                        cnt    <= '0;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    // Owner drop and forced rotation both collapse into one GAP transition.
                    if (!owner_req || (expired && others_req)) begin
                        state  <= GAP;
                        ptr    <= owner + IDX_W'(1);
                        cnt    <= '0;
                        enable <= 1'b0;
                        busy   <= 1'b1;
                    end else if (expired) begin
                        // Nobody else waiting: re-grant the same owner without a gap.
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    assign address0 = owner[0];
    assign address1 = owner[1];

endmodule
